icache_fill_ctrl: RTL
=====================

Name: icache_fill_ctrl

Overview:
- Refill engine for the special icache: the write side of the per-set tag/valid/data arrays.
- On a miss, captures the address and runs a 4-beat burst read from physical memory, assembling a 256-bit line.
- Then writes line, tag and valid into the selected way for one cycle, using the arrays' load/windex/datain ports.
- Read-side lookup logic sees the new line in the write cycle via the arrays' same-index write-bypass, so the hit is satisfied without an extra cycle.

Parameters:
ADDR_W, 32, byte address width
OFFSET_W, 5, line offset bits (32-byte line)
INDEX_W, 6, set index bits (64 sets, matches array depth)
BEAT_W, 64, memory beat width
BEATS, 4, beats per line (BEATS*BEAT_W = 256)
WAYS, 2, associativity

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
miss_req  input  1  lookup missed; start a refill (sampled in IDLE only)
miss_addr  input  ADDR_W  missing address
lru_way  input  $clog2(WAYS)  victim way from LRU logic, sampled with miss_req
flush  input  1  discard the in-flight refill (no array write)
busy  output  1  refill in progress
fill_done  output  1  one-cycle pulse in the array-write cycle
pmem_read  output  1  burst read request to memory
pmem_addr  output  ADDR_W  line-aligned burst address
pmem_resp  input  1  one beat valid on pmem_rdata
pmem_rdata  input  BEAT_W  beat data
array_load  output  WAYS  per-way write enable to the tag/valid/data arrays
array_windex  output  INDEX_W  write set index
array_tag  output  ADDR_W-INDEX_W-OFFSET_W  tag written (21 bits)
array_valid  output  1  valid bit written (always 1 when loading)
array_line  output  BEATS*BEAT_W  assembled line

Behaviour:
- Reset (rst low, async): state IDLE, beat counter 0, abort flag 0, line buffer 0. All outputs 0: busy, fill_done, pmem_read, pmem_addr, array_load, array_windex, array_tag, array_valid, array_line.
- FSM states: IDLE, FETCH, WRITE.
- IDLE:
  - When miss_req=1, register:
    - pmem_addr = miss_addr with low OFFSET_W bits cleared
    - index = miss_addr[10:5]
    - tag = miss_addr[31:11]
    - way = lru_way
  - Clear beat counter and abort flag; go to FETCH.
  - busy rises the next cycle.
  - miss_req is ignored in every state other than IDLE.
- FETCH:
  - pmem_read=1 and pmem_addr stable until the beat that completes the burst.
  - Each pmem_resp: pmem_rdata written to line bits [BEAT_W*k +: BEAT_W], k = beat counter; counter increments.
  - On the beat with k=BEATS-1, pmem_read drops the next cycle.
  - If abort flag=0, go to WRITE; else go to IDLE with no write and no fill_done.
  - flush during FETCH sets the abort flag; the burst always completes, because the memory protocol has no cancel.
- WRITE (exactly one cycle):
  - array_load[way]=1, other ways 0.
  - array_windex=index, array_tag=tag, array_valid=1, array_line=line buffer, fill_done=1.
  - Next state IDLE; busy=0 from the next cycle.
  - flush in WRITE: the write still completes, since the data is consistent.
- Minimum latency, miss_req to fill_done: 1 + BEATS cycles (beats back-to-back) + 1. Gaps between beats stretch FETCH only.
- flush in IDLE: no effect.
- flush together with miss_req in IDLE: the refill starts with the abort flag set, so the burst is fetched and dropped.
- array_* outputs are combinationally 0 outside WRITE, except array_windex/array_tag, which hold their last values.
- Beat counter width $clog2(BEATS). Wrap to 0 after the last beat is don't-care because it is cleared on entry to FETCH.

Decomposition:
- Shared package icache_pkg holds:
  - widths: OFFSET_W, INDEX_W, TAG_W = ADDR_W-INDEX_W-OFFSET_W, LINE_W
  - state enum fill_state_t {IDLE, FETCH, WRITE}
  - address-field extract functions
- One natural sub-module: line_assembler (beat counter + 256-bit shift/indexed buffer, last_beat flag). The FSM stays in icache_fill_ctrl.

Test Plan:
- Basic refill: miss_addr=0x0000_1234, lru_way=1, beats 0x11..1,0x22..2,0x33..3,0x44..4 back-to-back.
  - pmem_addr=0x0000_1220 and pmem_read high for 4 cycles.
  - Then array_load=2'b10, windex=0x11, tag=0x000002, line={0x44..,0x33..,0x22..,0x11..}, fill_done high for one cycle, 6 cycles after miss_req.
- Stalled memory: 2 idle cycles between each beat.
  - pmem_read held high and pmem_addr stable throughout; same line assembled.
  - fill_done 12 cycles after miss_req.
- Flush mid-burst: flush after beat 2.
  - Remaining beats consumed, then IDLE; array_load never asserted, fill_done never pulses.
  - A new miss_req is accepted on the following cycle.
- Busy rejection: second miss_req (addr 0x0000_2000) during FETCH.
  - Ignored; only the first line is written; pmem_addr never changes to 0x0000_2000.
- Async reset mid-FETCH: rst low after beat 1 (asynchronous to clk edge).
  - All outputs 0 immediately; after release, a fresh miss fetches cleanly from beat 0.
- Back-to-back misses: miss_req held high across WRITE.
  - Second refill starts the cycle after WRITE (IDLE sample); way/index are those of the second address.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths, FSM encodings and address-field helpers for the icache refill path.
package icache_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int INDEX_W  = 6;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;
    localparam int LINE_W   = BEATS * BEAT_W;
    localparam int WAYS     = 2;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } fill_state_t;

    // Plain-vector views of the enum so the state register stays a simple logic vector.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_WRITE = WRITE;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/icache_fill_ctrl_line_assembler.sv
// Collects memory beats into a full cache line; beat k lands in line slice k.
module line_assembler
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            line <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (beat_valid) begin
            line[int'(cnt) * BEAT_W +: BEAT_W] <= beat_data;
            cnt                                <= cnt + 1'b1;
        end
    end

    assign last_beat = (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_fill_ctrl.sv
// Icache refill engine: captures a miss, bursts the line in from memory, then writes one way.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic [WAY_W-1:0]    lru_way,
    input  logic                flush,
    output logic                busy,
    output logic                fill_done,
    output logic                pmem_read,
    output logic [ADDR_W-1:0]   pmem_addr,
    input  logic                pmem_resp,
    input  logic [BEAT_W-1:0]   pmem_rdata,
    output logic [WAYS-1:0]     array_load,
    output logic [INDEX_W-1:0]  array_windex,
    output logic [TAG_W-1:0]    array_tag,
    output logic                array_valid,
    output logic [LINE_W-1:0]   array_line
);

    logic [1:0]          state;
    logic [INDEX_W-1:0]  index_q;
    logic [TAG_W-1:0]    tag_q;
    logic [WAY_W-1:0]    way_q;
    logic                abort_q;
    logic [LINE_W-1:0]   line_buf;
    logic                last_beat;
    logic                start;
    logic                in_fetch;
    logic                in_write;

    assign in_fetch = (state == ST_FETCH);
    assign in_write = (state == ST_WRITE);
    assign start    = (state == ST_IDLE) && miss_req;

    line_assembler u_line (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .beat_valid (in_fetch && pmem_resp),
        .beat_data  (pmem_rdata),
        .line       (line_buf),
        .last_beat  (last_beat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pmem_addr <= '0;
            index_q   <= '0;
            tag_q     <= '0;
            way_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_req) begin
                        pmem_addr <= line_base(miss_addr);
                        index_q   <= addr_index(miss_addr);
                        tag_q     <= addr_tag(miss_addr);
                        way_q     <= lru_way;
                        abort_q   <= flush;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Memory has no cancel: a flush only marks the burst to be dropped.
                    if (flush) abort_q <= 1'b1;
                    if (pmem_resp && last_beat) begin
                        state <= (abort_q || flush) ? ST_IDLE : ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state != ST_IDLE);
    assign pmem_read    = in_fetch;
    assign fill_done    = in_write;
    assign array_valid  = in_write;
    assign array_line   = in_write ? line_buf : '0;
    assign array_windex = index_q;
    assign array_tag    = tag_q;

    always_comb begin
        array_load = '0;
        if (in_write) array_load[way_q] = 1'b1;
    end

endmodule
